data_ram: RTL and testbench
===========================

# data_ram

Parametrised single-port data memory for the load/store stage, succeeding the fixed-width word RAM. It adds a request/response handshake, per-byte write strobes, registered read data, alignment/range error reporting and an optional post-reset clearing sequence. It sits between the memory-access stage and on-chip storage. It accepts one request per cycle and returns one response per accepted request.

## Interface
- `DATA_W`, 32: data width in bits; a multiple of 8, at least 8.
- `DEPTH`, 1024: number of `DATA_W` words; need not be a power of two.
- `ADDR_W`, 32: byte-address width.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-low reset (`RstEnable` = 1'b0).
- `req_i` input 1: request; accepted when `req_i && ready_o` at a rising edge.
- `we_i` input 1: 1 = write, 0 = read.
- `addr_i` input `ADDR_W`: byte address.
- `wdata_i` input `DATA_W`: write data.
- `be_i` input `DATA_W/8`: byte enables; bit k covers `wdata_i[8k+7:8k]`.
- `ready_o` output 1: block can accept a request.
- `rvalid_o` output 1: one-cycle response pulse for each accepted request.
- `rdata_o` output `DATA_W`: read data, meaningful when `rvalid_o` = 1.
- `err_o` output 1: error flag, qualified by `rvalid_o`.

## Operation
- Byte offset width: OFS = log2(`DATA_W/8`). Word index: `addr_i[ADDR_W-1:OFS]`.
- Error conditions:
  - Misaligned: `addr_i[OFS-1:0]` ≠ 0 (only applies when OFS > 0).
  - Out of range: word index ≥ `DEPTH`.
- On an erroring request:
  - No storage is modified.
  - Response carries `err_o`=1 and `rdata_o`=0.
- Accepted write without error:
  - Each lane with `be_i[k]`=1 is updated; other lanes are unchanged.
  - `be_i`=0 still gets a response.
  - Response carries `rdata_o`=0 and `err_o`=0.
- Accepted read without error: `rdata_o` is the full word at the index as of the accept edge.
- Outputs hold between responses:
  - `rdata_o` and `err_o` keep their last values while `rvalid_o`=0.
  - `rvalid_o` is never high for more than one cycle per accepted request.
- Requests while `ready_o`=0 are ignored and get no response.
- Requests are in-order and never stall once `ready_o`=1; full throughput is 1 per cycle.
- FSM (with `DATA_RAM_CLEAR_EN`), two states:
  - CLEAR: counter `clr_idx` runs 0..`DEPTH-1`, writing all-zero words; `ready_o`=0. Moves to IDLE after writing `DEPTH-1`.
  - IDLE: `ready_o`=1; normal operation. Stays in IDLE until reset.
  - Reset entry: `rst`=0 forces CLEAR with `clr_idx`=0.
- Reset mid-operation, at any state:
  - Clears all outputs and any pending response; a request accepted in the cycle before reset produces no response.
  - Reset mid-CLEAR restarts clearing from index 0.

## Timing
- Reset values: `ready_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `clr_idx`=0.
- Response latency: request accepted at edge N gives `rvalid_o`/`rdata_o`/`err_o` valid in the cycle after edge N, registered at edge N.
- Read-after-write:
  - Write at edge N, read of the same word at edge N+1 returns the new data.
  - No same-cycle hazard exists, since the port is single.
- With `DATA_RAM_CLEAR_EN`:
  - `ready_o` rises exactly `DEPTH` cycles after the first edge with `rst`=1.
  - The first request can be accepted at that edge.
- Without `DATA_RAM_CLEAR_EN`: `ready_o`=1 from the first edge with `rst`=1.

## Configuration
- `DATA_RAM_CLEAR_EN` defined:
  - CLEAR state and `clr_idx` counter are present.
  - All words read 0 after clearing completes.
- `DATA_RAM_CLEAR_EN` undefined:
  - No FSM or counter; the block is permanently IDLE after reset.
  - Memory contents are undefined until written; the bench must not expect values from unwritten words.

## Test plan
- Reset then idle, with `DATA_RAM_CLEAR_EN`, `DEPTH`=16:
  - `ready_o`=0 for 16 cycles after `rst` deasserts, then 1.
  - Read of `addr_i`=0x3C returns 0x00000000 with `err_o`=0.
- Byte-masked write:
  - Write 0xAABBCCDD to 0x8 with `be_i`=4'b1111.
  - Then write 0x11223344 with `be_i`=4'b0101.
  - Read of 0x8 returns 0xAA22CC44.
- Back-to-back traffic:
  - Write 0x12345678 to 0x10 at edge N, read 0x10 at edge N+1.
  - `rvalid_o` is high in both following cycles.
  - The second response carries 0x12345678.
- Errors:
  - Read of 0x6 (misaligned) gives `err_o`=1, `rdata_o`=0.
  - Write to word index `DEPTH` gives `err_o`=1, and a later read of index 0 is unchanged.
- Reset mid-clear:
  - Assert `rst`=0 for one cycle at clear index 7.
  - `ready_o` rises `DEPTH` cycles after the release.
  - A request presented during CLEAR gets no response.

Source files
------------

// File: rtl/data_ram.sv
// data_ram: single-port data memory for the load/store stage.
// Request/response handshake, per-byte write strobes, registered read data,
// and alignment/range error reporting.
// Optional macro DATA_RAM_CLEAR_EN adds a post-reset sequence that zeroes
// every word before the block accepts its first request.
module data_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic                ready_o,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o
);

    localparam int LANES  = DATA_W / 8;
    localparam int OFS    = $clog2(LANES);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX_W = ADDR_W - OFS;

    // One extra bit so DEPTH itself is representable for the range check.
    localparam logic [WIDX_W:0] DEPTH_LIM = (WIDX_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [WIDX_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              bad;
    logic              ready;
    logic              accept;
    logic              clr_we;

    // Response registers (one stage after the accept edge).
    logic              rvalid_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;

    assign word_idx     = addr_i[ADDR_W-1:OFS];
    assign mem_idx      = word_idx[IDX_W-1:0];
    assign out_of_range = ({1'b0, word_idx} >= DEPTH_LIM);

    generate
        if (OFS > 0) begin : g_align
            assign misaligned = |addr_i[OFS-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    assign bad = misaligned | out_of_range;

    // Requests landing on a reset edge are dropped along with everything else.
    assign accept = req_i & ready & rst;

`ifdef DATA_RAM_CLEAR_EN
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] clr_idx;
    logic [IDX_W-1:0] clr_idx_nxt;

    // State and clear-counter register; reset restarts clearing at index 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Walk every index once writing zeros, then stay idle until reset.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        clr_we      = 1'b0;
        ready       = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_nxt   = IDLE;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            IDLE: begin
                ready = 1'b1;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end
`else
    logic ready_q;

    // Without clearing the block is usable from the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ready  = ready_q;
    assign clr_we = 1'b0;
`endif

    // Storage update: clearing has priority, otherwise byte-lane masked writes.
    always_ff @(posedge clk) begin
        if (clr_we && rst) begin
`ifdef DATA_RAM_CLEAR_EN
            mem[clr_idx] <= '0;
`endif
        end else if (accept && we_i && !bad) begin
            for (int k = 0; k < LANES; k++) begin
                if (be_i[k]) begin
                    mem[mem_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response stage: one pulse per accepted request, data/err held otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid_p1 <= 1'b0;
            rdata_p1  <= '0;
            err_p1    <= 1'b0;
        end else begin
            rvalid_p1 <= accept;
            if (accept) begin
                err_p1 <= bad;
                if (bad || we_i) begin
                    rdata_p1 <= '0;
                end else begin
                    rdata_p1 <= mem[mem_idx];
                end
            end
        end
    end

    assign ready_o  = ready;
    assign rvalid_o = rvalid_p1;
    assign rdata_o  = rdata_p1;
    assign err_o    = err_p1;

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram (DEPTH=16, DATA_W=32). Works with and without
// DATA_RAM_CLEAR_EN; without it, all words are written before being read.
module tb_data_ram;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    always #5 clk = ~clk;

    data_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .be_i     (be),
        .ready_o  (ready),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err)
    );

    // Behavioural reference: memory array, edge counter since reset, response.
    logic [31:0] m_mem [DEPTH];
    bit          m_ready = 1'b0;
    int          rel     = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_rdata = '0;
    bit          m_err   = 1'b0;
    bit          acc;
    bit          bad;

    always @(posedge clk) begin
        if (!rst) begin
            rel     = 0;
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_rdata = '0;
            m_err   = 1'b0;
`ifdef DATA_RAM_CLEAR_EN
            foreach (m_mem[i]) m_mem[i] = '0;
`endif
        end else begin
            acc     = req && m_ready;
            m_valid = acc;
            if (acc) begin
                bad   = (addr % 4 != 0) || (addr / 4 >= DEPTH);
                m_err = bad;
                if (bad) begin
                    m_rdata = '0;
                end else if (we) begin
                    m_rdata = '0;
                    for (int k = 0; k < 4; k++)
                        if (be[k]) m_mem[addr / 4][8*k +: 8] = wdata[8*k +: 8];
                end else begin
                    m_rdata = m_mem[addr / 4];
                end
            end
            rel++;
`ifdef DATA_RAM_CLEAR_EN
            m_ready = (rel >= DEPTH);
`else
            m_ready = (rel >= 1);
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Every cycle: outputs must match the model (including held values).
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready_o", {31'b0, ready}, {31'b0, m_ready});
            chk("rvalid_o", {31'b0, rvalid}, {31'b0, m_valid});
            chk("rdata_o", rdata, m_rdata);
            chk("err_o", {31'b0, err}, {31'b0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0;
    endtask

    // Issue one request, then check its response against literal values.
    task automatic single(input string name, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input logic [31:0] exp_d, input bit exp_e);
        int n = 0;
        while (!m_ready && n < 100) begin
            tick();
            n++;
        end
        if (!m_ready) chk({name, "_ready_wait"}, {31'b0, m_ready}, 32'd1);
        drive(w, a, d, b);
        tick();
        idle();
        @(negedge clk);
        chk({name, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        chk({name, "_rdata"}, rdata, exp_d);
        chk({name, "_err"}, {31'b0, err}, {31'b0, exp_e});
    endtask

    // Count cycles with ready_o low until it rises; also note any response.
    task automatic count_clear(input string name, input int exp_cycles);
        int cnt = 0;
        int rv_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
            cnt++;
            if (rvalid !== 1'b0) rv_seen++;
        end
        chk({name, "_cycles"}, cnt, exp_cycles);
        chk({name, "_no_resp"}, rv_seen, 0);
    endtask

    initial begin
        int sel;
        rst = 1'b0;
        repeat (3) tick();
        cmp_en = 1'b1;
        rst = 1'b1;
`ifdef DATA_RAM_CLEAR_EN
        count_clear("reset_clear", DEPTH);
`else
        count_clear("reset_ready", 1);
        for (int i = 0; i < DEPTH; i++) single("init", 1'b1, 32'(i * 4), 32'h0, 4'hF, 32'h0, 1'b0);
`endif
        single("rd_3c", 1'b0, 32'h3C, 32'h0, 4'h0, 32'h0000_0000, 1'b0);

        single("wr_full", 1'b1, 32'h8, 32'hAABB_CCDD, 4'b1111, 32'h0, 1'b0);
        single("wr_mask", 1'b1, 32'h8, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        single("rd_mask", 1'b0, 32'h8, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0);

        // Back-to-back write then read of the same word.
        drive(1'b1, 32'h10, 32'h1234_5678, 4'hF);
        @(posedge clk); #1;
        drive(1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("b2b_wr_rvalid", {31'b0, rvalid}, 32'd1);
        chk("b2b_wr_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("b2b_rd_rvalid", {31'b0, rvalid}, 32'd1);
        chk("b2b_rd_rdata", rdata, 32'h1234_5678);

        single("rd_misalign", 1'b0, 32'h6, 32'h0, 4'h0, 32'h0, 1'b1);
        single("wr_w0", 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        single("wr_oor", 1'b1, 32'(DEPTH * 4), 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
        single("rd_w0_a", 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        single("wr_be0", 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
        single("rd_w0_b", 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        single("wr_misal", 1'b1, 32'h1, 32'h5555_5555, 4'hF, 32'h0, 1'b1);
        single("rd_w0_c", 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            sel   = int'($urandom_range(0, 7));
            req   = ($urandom_range(0, 9) < 7);
            we    = $urandom_range(0, 1) == 1;
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            if (sel == 0)      addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 1) addr = (32'($urandom) | 32'h0000_0040) & 32'hFFFF_FFFC;
            else               addr = 32'($urandom_range(0, DEPTH - 1) * 4);
        end
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);

        // Reset again; with clearing, interrupt it at index 7.
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
`ifdef DATA_RAM_CLEAR_EN
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        rst = 1'b1;
        count_clear("midclear", DEPTH);
        idle();
        for (int i = 0; i < DEPTH; i++) single("post_clear", 1'b0, 32'(i * 4), 32'h0, 4'h0, 32'h0, 1'b0);
`else
        count_clear("rereset_ready", 1);
        for (int i = 0; i < DEPTH; i++) single("reinit", 1'b1, 32'(i * 4), 32'h0, 4'hF, 32'h0, 1'b0);
`endif
        single("final_wr", 1'b1, 32'h14, 32'h0BAD_F00D, 4'b1000, 32'h0, 1'b0);
        single("final_rd", 1'b0, 32'h14, 32'h0, 4'h0, 32'h0B00_0000, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
